// File: rtl/prbs_pkg.sv
// Mode encodings, polynomial tap masks and width helpers shared by the PRBS transmit engine.
package prbs_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'b00,
    MODE_PRBS13 = 2'b01,
    MODE_PRBS15 = 2'b10,
    MODE_PRBS31 = 2'b11
  } prbs_mode_e;

  localparam int LFSR_W = 31;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

  localparam int W_PRBS7  = 7;
  localparam int W_PRBS13 = 13;
  localparam int W_PRBS15 = 15;
  localparam int W_PRBS31 = 31;

  // Bit j of a mask taps s[j]; x^k of the polynomial maps to s[k-1].
  localparam logic [LFSR_W-1:0] TAPS_PRBS7  = 31'h0000_0060;
  localparam logic [LFSR_W-1:0] TAPS_PRBS13 = 31'h0000_1803;
  localparam logic [LFSR_W-1:0] TAPS_PRBS15 = 31'h0000_6000;
  localparam logic [LFSR_W-1:0] TAPS_PRBS31 = 31'h4800_0000;

  function automatic int mode_width(prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return W_PRBS7;
      MODE_PRBS13: return W_PRBS13;
      MODE_PRBS15: return W_PRBS15;
      default:     return W_PRBS31;
    endcase
  endfunction

  function automatic logic [LFSR_W-1:0] mode_taps(prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return TAPS_PRBS7;
      MODE_PRBS13: return TAPS_PRBS13;
      MODE_PRBS15: return TAPS_PRBS15;
      default:     return TAPS_PRBS31;
    endcase
  endfunction

  function automatic logic [LFSR_W-1:0] width_mask(prbs_mode_e m);
    return LFSR_SEED >> (LFSR_W - mode_width(m));
  endfunction

endpackage

// File: rtl/prbs_lfsr_multi.sv
// Multi-polynomial Fibonacci LFSR with lock-up recovery; emits one (optionally inverted) bit per advance.
module prbs_lfsr_multi
  import prbs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       adv,
  input  logic       reload,
  input  logic       inj,
  output logic       out_bit
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] tap_mask, act_mask;
  logic              fb;
  logic              locked;

  // Bits above the active width still shift but never reach the taps or the lock-up test.
  always_comb begin
    tap_mask = mode_taps(prbs_mode_e'(mode));
    act_mask = width_mask(prbs_mode_e'(mode));
    fb       = ^(lfsr_q & tap_mask);
    locked   = ((lfsr_q & act_mask) == '0);
    out_bit  = fb ^ inj;
    lfsr_d   = lfsr_q;
    if (reload) begin
      lfsr_d = LFSR_SEED;
    end else if (adv) begin
      lfsr_d = locked ? LFSR_SEED : {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/prbs_tx_engine.sv
// PRBS transmit engine: multi-mode LFSR, signed FIR pre-emphasis, valid/ready output,
// single-bit error injection and bit/error counters.
module prbs_tx_engine
  import prbs_pkg::*;
#(
  parameter int NTAPS = 3,
  parameter int TAP_W = 4,
  parameter int OUT_W = 13,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [NTAPS*TAP_W-1:0] taps,
  input  logic                   load_taps,
  input  logic                   inj_err,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic [CNT_W-1:0]       bit_count,
  output logic [CNT_W-1:0]       err_count
);

  localparam int FILL_W = $clog2(NTAPS + 1);
  localparam logic [FILL_W-1:0]      FILL_FULL = FILL_W'(NTAPS);
  localparam logic [FILL_W-1:0]      FILL_LAST = FILL_W'(NTAPS - 1);
  localparam logic [NTAPS*TAP_W-1:0] COEF_RST  = (NTAPS*TAP_W)'(1);

  if (OUT_W < TAP_W + $clog2(NTAPS) + 1) begin : g_out_w_check
    $error("prbs_tx_engine: OUT_W too narrow for TAP_W and NTAPS");
  end

  // Asynchronous assert, synchronous release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  prbs_mode_e             mode_q, mode_d;
  logic [NTAPS*TAP_W-1:0] coef_q, coef_d;
  logic [NTAPS-1:0]       hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   pending_q, pending_d;
  logic                   valid_q, valid_d;
  logic [OUT_W-1:0]       data_q, data_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

  logic adv, mode_chg, lfsr_adv, inj_eff, new_bit;
  logic signed [OUT_W-1:0] sample, coef_ext;

  assign adv      = en && (!valid_q || out_ready);
  assign mode_chg = (mode != mode_q);
  assign lfsr_adv = adv && !mode_chg;
  assign inj_eff  = pending_q || inj_err;

  prbs_lfsr_multi u_lfsr (
    .clk     (clk),
    .reset   (rst_n_int),
    .mode    (mode_q),
    .adv     (lfsr_adv),
    .reload  (mode_chg),
    .inj     (inj_eff),
    .out_bit (new_bit)
  );

  // hist_shift[0] is the bit emitted on this advance, so c0 weights the newest symbol.
  assign hist_shift = (hist_q << 1) | NTAPS'(new_bit);

  always_comb begin
    sample   = '0;
    coef_ext = '0;
    for (int k = 0; k < NTAPS; k++) begin
      coef_ext = {{(OUT_W-TAP_W){coef_q[k*TAP_W+TAP_W-1]}}, coef_q[k*TAP_W +: TAP_W]};
      if (hist_shift[k]) sample = sample + coef_ext;
      else               sample = sample - coef_ext;
    end
  end

  // NOTE: every next-state value defaults to its register first, so no path can infer a latch.
  always_comb begin
    mode_d    = mode_q;
    coef_d    = coef_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;

    if (load_taps) coef_d = taps;

    if (mode_chg) begin
      mode_d    = prbs_mode_e'(mode);
      fill_d    = '0;
      valid_d   = 1'b0;
      bit_cnt_d = '0;
      pending_d = 1'b0;
    end else if (adv) begin
      hist_d    = hist_shift;
      pending_d = 1'b0;
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (inj_eff) err_cnt_d = err_cnt_q + 1'b1;
      if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
      if (fill_q >= FILL_LAST) begin
        valid_d = 1'b1;
        data_d  = sample;
      end
    end else begin
      pending_d = inj_eff;
    end
  end

  // NOTE: the symbol history and coefficients are plain registers and are reset like all other state.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      mode_q    <= MODE_PRBS7;
      coef_q    <= COEF_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      mode_q    <= mode_d;
      coef_q    <= coef_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign bit_count = bit_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_tx_engine.sv
// Scoreboard bench for prbs_tx_engine: stimulus pushes expected samples, a negedge monitor pops on each handshake.
module tb_prbs_tx_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] taps = '0;
  logic        load_taps = 1'b0;
  logic        inj_err = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [12:0] out_data;
  logic [31:0] bit_count;
  logic [31:0] err_count;

  always #5 clk = ~clk;

  prbs_tx_engine #(.NTAPS(3), .TAP_W(4), .OUT_W(13), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .taps      (taps),
    .load_taps (load_taps),
    .inj_err   (inj_err),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .bit_count (bit_count),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  bit got_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sample_unexpected: got %0d with empty queue", $signed(out_data));
      end else begin
        check("sample", longint'($signed(out_data)), exp_q.pop_front());
        got_q.push_back(out_data == 13'd1);
      end
    end
  end

  // Reference model: e[n] = XOR of e[n-k] for each polynomial term x^k, seeded with all ones.
  logic [31:1] mh;
  logic [2:0]  mw;
  int          mfill;
  logic [1:0]  mmode;
  bit          minj;
  int          mc[3];
  int          last_exp;

  function automatic int sym(input logic b);
    return b ? 1 : -1;
  endfunction

  function automatic logic rec_bit();
    case (mmode)
      2'd0:    return mh[7] ^ mh[6];
      2'd1:    return mh[13] ^ mh[12] ^ mh[2] ^ mh[1];
      2'd2:    return mh[15] ^ mh[14];
      default: return mh[31] ^ mh[28];
    endcase
  endfunction

  task automatic model_adv(input bit push);
    logic t, e;
    t    = rec_bit();
    e    = t ^ minj;
    minj = 1'b0;
    mh   = {mh[30:1], t};
    mw   = {mw[1:0], e};
    if (mfill < 3) mfill++;
    last_exp = mc[0] * sym(mw[0]) + mc[1] * sym(mw[1]) + mc[2] * sym(mw[2]);
    if (mfill == 3 && push) exp_q.push_back(last_exp);
  endtask

  task automatic model_mode(input logic [1:0] m);
    mmode = m;
    mh    = '1;
    mfill = 0;
    minj  = 1'b0;
  endtask

  task automatic model_reset();
    model_mode(2'd0);
    mw = '0;
    mc = '{1, 0, 0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit push);
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      model_adv(push);
      tick();
    end
    en = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic set_taps(input int c0, input int c1, input int c2);
    taps = {4'(c2), 4'(c1), 4'(c0)};
    load_taps = 1'b1;
    tick();
    load_taps = 1'b0;
    mc = '{c0, c1, c2};
  endtask

  task automatic change_mode(input logic [1:0] m);
    mode = m;
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    en = 1'b0;
    out_ready = 1'b0;
    model_mode(m);
  endtask

  // c0=6, c1=-2, c2=0 on PRBS7 bits 0,0,0,0,0,0,1,0,0: samples for n=2..8.
  task automatic seq1();
    set_taps(6, -2, 0);
    exp_q.push_back(-4);
    exp_q.push_back(-4);
    exp_q.push_back(-4);
    exp_q.push_back(-4);
    exp_q.push_back(8);
    exp_q.push_back(-8);
    exp_q.push_back(-4);
    run(9, 1'b0);
    check("seq1_bit_count", bit_count, 9);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_bit_count"}, bit_count, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic check_period(input string name, input int period, input int exp_size);
    int mism;
    mism = 0;
    check({name, "_samples"}, got_q.size(), exp_size);
    for (int i = 0; i + period < got_q.size(); i++) begin
      if (got_q[i] != got_q[i + period]) mism++;
    end
    check({name, "_period"}, mism, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (3) tick();

    seq1();

    // Stall mid-stream: output must hold the last produced sample.
    run(4, 1'b1);
    en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", longint'($signed(out_data)), last_exp);
    end
    run(6, 1'b1);
    check("stall_bit_count", bit_count, 19);

    // Injection coincident with an advance.
    inj_err = 1'b1;
    minj = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    model_adv(1'b1);
    tick();
    inj_err = 1'b0;
    run(5, 1'b1);
    check("inj_err_count_1", err_count, 1);
    check("inj_bit_count", bit_count, 25);

    // Two strobes while disabled collapse into one inversion.
    inj_err = 1'b1;
    tick();
    inj_err = 1'b0;
    tick();
    inj_err = 1'b1;
    tick();
    inj_err = 1'b0;
    minj = 1'b1;
    run(6, 1'b1);
    check("inj_err_count_2", err_count, 2);
    check("inj_bit_count_2", bit_count, 31);

    // PRBS7 -> PRBS31 switch mid-run.
    change_mode(2'd3);
    check("mode_chg_valid", out_valid, 0);
    check("mode_chg_bit_count", bit_count, 0);
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      model_adv(1'b1);
      tick();
      check("refill_valid", out_valid, (i == 2) ? 1 : 0);
    end
    run(40, 1'b1);
    check("prbs31_err_count_kept", err_count, 2);

    // PRBS7 period 127 over 254 advances.
    set_taps(1, 0, 0);
    change_mode(2'd0);
    got_q.delete();
    run(254, 1'b1);
    check("prbs7_bit_count", bit_count, 254);
    check_period("prbs7", 127, 251);

    // PRBS15 period 32767.
    change_mode(2'd2);
    got_q.delete();
    run(32807, 1'b1);
    check("prbs15_bit_count", bit_count, 32807);
    check_period("prbs15", 32767, 32804);

    // Asynchronous reset during a stall, then sequence 1 again.
    en = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    #3 reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    model_reset();
    mode = 2'd0;
    en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    seq1();

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
